// File: rtl/alu_mul_slave.sv
// Memory-mapped ALU peripheral with an iterative radix-4 32x32 multiplier.
// Define ALU_MUL_EN to build the multiplier; without it opcode D returns 0 after one cycle.
module alu_mul_slave (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_addr,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b;
  logic [3:0]  opc;
  logic [31:0] snap_a, snap_b;
  logic [3:0]  snap_op;
  logic [63:0] res, alu_res;
  logic        wr_en, start_wr, clear_wr;
  logic        launch, fin, is_mul, mul_last;

  assign wr_en    = S_sel & S_wr;
  assign start_wr = wr_en && (S_addr == 8'h05) && S_din[0];
  assign clear_wr = wr_en && (S_addr == 8'h07) && S_din[0];

`ifdef ALU_MUL_EN
  logic [63:0] acc, mcand, pp;
  logic [31:0] mplr;
  logic [3:0]  cnt;

  assign is_mul   = (snap_op == 4'hD);
  assign mul_last = is_mul && (cnt == 4'd15);

  // Two multiplier bits per cycle select 0, 1x, 2x or 3x of the shifted multiplicand.
  always_comb begin
    pp = '0;
    case (mplr[1:0])
      2'd1:    pp = mcand;
      2'd2:    pp = mcand << 1;
      2'd3:    pp = mcand + (mcand << 1);
      default: pp = '0;
    endcase
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b0;
`endif

  always_comb begin
    logic [32:0] sum;
    alu_res = '0;
    sum     = '0;
    case (snap_op)
      4'h0: alu_res[31:0] = ~snap_a;
      4'h1: alu_res[31:0] = ~snap_b;
      4'h2: alu_res[31:0] = snap_a & snap_b;
      4'h3: alu_res[31:0] = snap_a | snap_b;
      4'h4: alu_res[31:0] = snap_a ^ snap_b;
      4'h5: alu_res[31:0] = ~(snap_a ^ snap_b);
      4'h6: alu_res[31:0] = ~(snap_a & snap_b);
      4'h7: alu_res[31:0] = ~(snap_a | snap_b);
      4'h8: alu_res[31:0] = snap_a << snap_b[4:0];
      4'h9: alu_res[31:0] = snap_a >> snap_b[4:0];
      4'hA: alu_res[31:0] = $signed(snap_a) >>> snap_b[4:0];
      4'hB: begin
        sum     = {1'b0, snap_a} + {1'b0, snap_b};
        alu_res = {31'b0, sum};
      end
      // Bit 32 of the widened difference is the borrow.
      4'hC: begin
        sum     = {1'b0, snap_a} - {1'b0, snap_b};
        alu_res = {31'b0, sum};
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE, DONE: if (start_wr) begin
        launch    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: if (!is_mul || mul_last) begin
        fin       = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_wr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a    <= '0;
      op_b    <= '0;
      opc     <= '0;
      snap_a  <= '0;
      snap_b  <= '0;
      snap_op <= '0;
      res     <= '0;
    end else begin
      if (wr_en) begin
        case (S_addr)
          8'h00:   op_a <= S_din;
          8'h01:   op_b <= S_din;
          8'h02:   opc  <= S_din[3:0];
          default: ;
        endcase
      end
      if (launch) begin
        snap_a  <= op_a;
        snap_b  <= op_b;
        snap_op <= opc;
      end
`ifdef ALU_MUL_EN
      if (fin) res <= is_mul ? acc + pp : alu_res;
`else
      if (fin) res <= alu_res;
`endif
      if (clear_wr) res <= '0;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (launch) begin
      acc   <= '0;
      mcand <= {32'b0, op_a};
      mplr  <= op_b;
      cnt   <= '0;
    end else if (state == EXEC && is_mul) begin
      acc   <= acc + pp;
      mcand <= mcand << 2;
      mplr  <= mplr >> 2;
      cnt   <= cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    S_dout = '0;
    if (S_sel && !S_wr) begin
      case (S_addr)
        8'h00:   S_dout = op_a;
        8'h01:   S_dout = op_b;
        8'h02:   S_dout = {28'b0, opc};
        8'h03:   S_dout = res[31:0];
        8'h04:   S_dout = res[63:32];
        8'h06:   S_dout = {30'b0, state == EXEC, state == DONE};
        default: S_dout = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_slave.sv
// Randomized bench for alu_mul_slave against a plain-arithmetic result model.
module tb_alu_mul_slave;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        S_sel = 1'b0, S_wr = 1'b0;
  logic [7:0]  S_addr = '0;
  logic [31:0] S_din = '0;
  logic [31:0] S_dout;
  int n_chk = 0, n_fail = 0;

  alu_mul_slave dut (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr),
    .S_addr(S_addr), .S_din(S_din), .S_dout(S_dout)
  );

  always #5 clk = ~clk;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  function automatic logic [63:0] ref_res(input logic [31:0] a, b, input logic [3:0] op);
    logic [63:0] r;
    logic signed [31:0] sa;
    int sh;
    sh = int'(b[4:0]);
    sa = a;
    r  = '0;
    case (op)
      4'h0: r = {32'b0, ~a};
      4'h1: r = {32'b0, ~b};
      4'h2: r = {32'b0, a & b};
      4'h3: r = {32'b0, a | b};
      4'h4: r = {32'b0, a ^ b};
      4'h5: r = {32'b0, ~(a ^ b)};
      4'h6: r = {32'b0, ~(a & b)};
      4'h7: r = {32'b0, ~(a | b)};
      4'h8: r = {32'b0, a << sh};
      4'h9: r = {32'b0, a >> sh};
      4'hA: r = {32'b0, 32'(sa >>> sh)};
      4'hB: r = {32'b0, a} + {32'b0, b};
      4'hC: r = {31'b0, (a < b), a - b};
      4'hD: r = MUL_EN ? {32'b0, a} * {32'b0, b} : 64'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    S_sel = 1'b1; S_wr = 1'b1; S_addr = a; S_din = d;
    @(posedge clk); #1;
    S_sel = 1'b0; S_wr = 1'b0; S_addr = '0; S_din = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b0; S_addr = a; #1;
    d = S_dout;
    S_sel = 1'b0; S_addr = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic [3:0] op);
    logic [63:0] e;
    int lat;
    e   = ref_res(a, b, op);
    lat = (op == 4'hD && MUL_EN) ? 16 : 1;
    wr(8'h00, a); wr(8'h01, b); wr(8'h02, {$urandom_range(0, 15), op});
    chk_rd("opcode_rb", 8'h02, {28'b0, op});
    chk_rd("opa_rb", 8'h00, a);
    wr(8'h05, 32'h1);
    chk_rd("busy_e0", 8'h06, 32'h2);
    for (int i = 1; i < lat; i++) begin
      step();
      chk_rd("busy_mid", 8'h06, 32'h2);
    end
    step();
    chk_rd("done", 8'h06, 32'h1);
    chk_rd("res_lo", 8'h03, e[31:0]);
    chk_rd("res_hi", 8'h04, e[63:32]);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] e;
    // Reset state
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) chk_rd($sformatf("rst_%0d", i), 8'(i), 32'h0);

    // ADD directed, with STATUS idle before START
    wr(8'h00, 32'h01230123); wr(8'h01, 32'h32103210); wr(8'h02, 32'hB);
    chk_rd("status_pre", 8'h06, 32'h0);
    S_sel = 1'b0; S_wr = 1'b0; S_addr = 8'h00; #1;
    chk("sel_low", S_dout, 32'h0);
    run_op(32'h01230123, 32'h32103210, 4'hB);
    chk_rd("add_lo_k", 8'h03, 32'h33333333);

    // CLEAR from DONE; operands retained; unmapped and RO writes ignored
    wr(8'h07, 32'h1);
    chk_rd("clr_status", 8'h06, 32'h0);
    chk_rd("clr_lo", 8'h03, 32'h0);
    chk_rd("clr_hi", 8'h04, 32'h0);
    wr(8'h14, 32'hFFFFFFFF);
    chk_rd("unmapped", 8'h14, 32'h0);
    chk_rd("opa_kept", 8'h00, 32'h01230123);
    wr(8'h03, 32'h12345678); wr(8'h06, 32'h3);
    chk_rd("ro_lo", 8'h03, 32'h0);
    chk_rd("ro_status", 8'h06, 32'h0);

    // Directed boundaries
    run_op(32'h00012345, 32'h00067890, 4'hD);
    if (MUL_EN) begin
      chk_rd("mul_lo_k", 8'h03, 32'h5CCA2ED0);
      chk_rd("mul_hi_k", 8'h04, 32'h00000007);
    end
    run_op(32'h0, 32'h1, 4'hC);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hD);
    run_op(32'hFFFFFFFF, 32'h1, 4'hB);
    run_op(32'h80000000, 32'h1F, 4'hA);

    // Random sweep over all opcodes
    for (int n = 0; n < 40; n++) begin
      a = $urandom(); b = $urandom();
      if (n % 8 == 0) a = 32'hFFFFFFFF;
      run_op(a, b, 4'($urandom_range(0, 15)));
    end

    // Operand write and START during MUL use the snapshot
    if (MUL_EN) begin
      a = $urandom(); b = $urandom();
      e = ref_res(a, b, 4'hD);
      wr(8'h00, a); wr(8'h01, b); wr(8'h02, 32'hD);
      wr(8'h05, 32'h1);
      step();
      wr(8'h00, 32'hDEADBEEF);
      wr(8'h05, 32'h1);
      wr(8'h01, 32'h5);
      for (int i = 5; i < 16; i++) begin
        step();
        chk_rd("snap_busy", 8'h06, 32'h2);
      end
      step();
      chk_rd("snap_done", 8'h06, 32'h1);
      chk_rd("snap_lo", 8'h03, e[31:0]);
      chk_rd("snap_hi", 8'h04, e[63:32]);
      chk_rd("new_opa", 8'h00, 32'hDEADBEEF);
    end

    // CLEAR on the finishing edge wins (non-MUL, then MUL)
    wr(8'h00, 32'h7); wr(8'h01, 32'h9); wr(8'h02, 32'hB);
    wr(8'h05, 32'h1);
    wr(8'h07, 32'h1);
    chk_rd("clrfin_status", 8'h06, 32'h0);
    chk_rd("clrfin_lo", 8'h03, 32'h0);
    step();
    chk_rd("clrfin_lo2", 8'h03, 32'h0);
    wr(8'h01, 32'h12345); wr(8'h02, 32'hD);
    wr(8'h05, 32'h1);
    if (MUL_EN) repeat (15) step();
    wr(8'h07, 32'h1);
    chk_rd("clrmul_status", 8'h06, 32'h0);
    chk_rd("clrmul_lo", 8'h03, 32'h0);
    chk_rd("clrmul_hi", 8'h04, 32'h0);

    // Reset pulse mid-MUL
    wr(8'h00, 32'hFFFF0000); wr(8'h01, 32'hFFFF); wr(8'h02, 32'hD);
    wr(8'h05, 32'h1);
    repeat (5) step();
    reset_n = 1'b0; #1;
    for (int i = 0; i < 8; i++) chk_rd($sformatf("midrst_%0d", i), 8'(i), 32'h0);
    reset_n = 1'b1;
    repeat (20) step();
    chk_rd("postrst_status", 8'h06, 32'h0);
    chk_rd("postrst_lo", 8'h03, 32'h0);
    chk_rd("postrst_hi", 8'h04, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
